// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus: ID-side fields and hazard controls in, EX-side fields out.
// The slave modport is the register itself; the master modport is the ID stage / hazard unit.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              stall_i;
  logic              flush_i;
  logic              valid_i;
  logic [1:0]        alu_op_i;
  logic [3:0]        funct_i;
  logic              alu_src_i;
  logic              reg_write_i;
  logic              mem_read_i;
  logic              mem_write_i;
  logic              mem_to_reg_i;
  logic              branch_i;
  logic [DATA_W-1:0] pc_i;
  logic [DATA_W-1:0] rs1_data_i;
  logic [DATA_W-1:0] rs2_data_i;
  logic [DATA_W-1:0] imm_i;
  logic [REG_AW-1:0] rs1_addr_i;
  logic [REG_AW-1:0] rs2_addr_i;
  logic [REG_AW-1:0] rd_addr_i;

  logic              valid_o;
  logic [1:0]        alu_op_o;
  logic [3:0]        funct_o;
  logic              alu_src_o;
  logic              reg_write_o;
  logic              mem_read_o;
  logic              mem_write_o;
  logic              mem_to_reg_o;
  logic              branch_o;
  logic [DATA_W-1:0] pc_o;
  logic [DATA_W-1:0] rs1_data_o;
  logic [DATA_W-1:0] rs2_data_o;
  logic [DATA_W-1:0] imm_o;
  logic [REG_AW-1:0] rs1_addr_o;
  logic [REG_AW-1:0] rs2_addr_o;
  logic [REG_AW-1:0] rd_addr_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output stall_i, flush_i, valid_i, alu_op_i, funct_i,
           alu_src_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, branch_i,
           pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
    input  valid_o, alu_op_o, funct_o,
           alu_src_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o,
           pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
           bubble_cnt_o
  );

  modport slave (
    input  stall_i, flush_i, valid_i, alu_op_i, funct_i,
           alu_src_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, branch_i,
           pc_i, rs1_data_i, rs2_data_i, imm_i, rs1_addr_i, rs2_addr_i, rd_addr_i,
    output valid_o, alu_op_o, funct_o,
           alu_src_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, branch_o,
           pc_o, rs1_data_o, rs2_data_o, imm_o, rs1_addr_o, rs2_addr_o, rd_addr_o,
           bubble_cnt_o
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall (hold), flush (bubble insertion), valid bit
// and a saturating count of inserted bubbles.
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  id_ex_pipe_reg_if.slave  bus
);

  logic              valid_q;
  logic [1:0]        alu_op_q;
  logic [3:0]        funct_q;
  logic              alu_src_q;
  logic              reg_write_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic              mem_to_reg_q;
  logic              branch_q;
  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] rs1_data_q;
  logic [DATA_W-1:0] rs2_data_q;
  logic [DATA_W-1:0] imm_q;
  logic [REG_AW-1:0] rs1_addr_q;
  logic [REG_AW-1:0] rs2_addr_q;
  logic [REG_AW-1:0] rd_addr_q;
  logic [CNT_W-1:0]  bubble_cnt_q;

  logic load_bubble;
  logic load_real;

  // An invalid ID slot is loaded exactly like a flush; a stall only holds when no flush is pending.
  always_comb begin
    load_bubble = bus.flush_i || (!bus.stall_i && !bus.valid_i);
    load_real   = !bus.flush_i && !bus.stall_i && bus.valid_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || load_bubble) begin
      valid_q      <= 1'b0;
      alu_op_q     <= 2'b00;
      funct_q      <= 4'b0000;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
      pc_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
    end else if (load_real) begin
      valid_q      <= 1'b1;
      alu_op_q     <= bus.alu_op_i;
      funct_q      <= bus.funct_i;
      alu_src_q    <= bus.alu_src_i;
      reg_write_q  <= bus.reg_write_i;
      mem_read_q   <= bus.mem_read_i;
      mem_write_q  <= bus.mem_write_i;
      mem_to_reg_q <= bus.mem_to_reg_i;
      branch_q     <= bus.branch_i;
      pc_q         <= bus.pc_i;
      rs1_data_q   <= bus.rs1_data_i;
      rs2_data_q   <= bus.rs2_data_i;
      imm_q        <= bus.imm_i;
      rs1_addr_q   <= bus.rs1_addr_i;
      rs2_addr_q   <= bus.rs2_addr_i;
      rd_addr_q    <= bus.rd_addr_i;
    end
  end

  // Bubble counter sticks at all-ones so a long debug run never reads back as small.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bubble_cnt_q <= '0;
    end else if (load_bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_q <= bubble_cnt_q + CNT_W'(1);
    end
  end

  assign bus.valid_o      = valid_q;
  assign bus.alu_op_o     = alu_op_q;
  assign bus.funct_o      = funct_q;
  assign bus.alu_src_o    = alu_src_q;
  assign bus.reg_write_o  = reg_write_q;
  assign bus.mem_read_o   = mem_read_q;
  assign bus.mem_write_o  = mem_write_q;
  assign bus.mem_to_reg_o = mem_to_reg_q;
  assign bus.branch_o     = branch_q;
  assign bus.pc_o         = pc_q;
  assign bus.rs1_data_o   = rs1_data_q;
  assign bus.rs2_data_o   = rs2_data_q;
  assign bus.imm_o        = imm_q;
  assign bus.rs1_addr_o   = rs1_addr_q;
  assign bus.rs2_addr_o   = rs2_addr_q;
  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.bubble_cnt_o = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg: vector table plus hand sequences for
// multi-cycle stall, counter saturation (4-bit counter) and reset during stall.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_op;
    logic [3:0]  funct;
    logic [5:0]  ctrl;   // {alu_src, reg_write, mem_read, mem_write, mem_to_reg, branch}
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
  } payload_t;

  typedef struct packed {
    payload_t   p;
    logic [3:0] cnt;
  } out_t;

  typedef struct {
    logic     rst;
    logic     stall;
    logic     flush;
    payload_t in_p;
    out_t     exp;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  out_t exp_q[$];
  string name_q[$];
  vec_t vecs[11];

  id_ex_pipe_reg_if #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) bus ();

  id_ex_pipe_reg #(.DATA_W(32), .REG_AW(5), .CNT_W(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic payload_t pl(input logic v, input logic [1:0] op, input logic [3:0] fn,
                                  input logic [5:0] ctrl, input logic [31:0] pc,
                                  input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                                  input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] rd);
    payload_t r;
    r.valid = v; r.alu_op = op; r.funct = fn; r.ctrl = ctrl; r.pc = pc;
    r.rs1_data = a; r.rs2_data = b; r.imm = imm;
    r.rs1_addr = ra1; r.rs2_addr = ra2; r.rd_addr = rd;
    return r;
  endfunction

  function automatic vec_t mkv(input logic r, input logic s, input logic f,
                               input payload_t in_p, input payload_t exp_p, input logic [3:0] cnt);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.in_p = in_p;
    v.exp.p = exp_p; v.exp.cnt = cnt;
    return v;
  endfunction

  function automatic payload_t rand_payload();
    return pl(1'($urandom), 2'($urandom), 4'($urandom), 6'($urandom), $urandom,
              $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 5'($urandom));
  endfunction

  // Drives one cycle of stimulus and records what the register must show after the next edge.
  task automatic applyStimulus(input logic r, input logic s, input logic f, input payload_t p,
                               input out_t exp, input string name);
    rst              = r;
    bus.stall_i      = s;
    bus.flush_i      = f;
    bus.valid_i      = p.valid;
    bus.alu_op_i     = p.alu_op;
    bus.funct_i      = p.funct;
    {bus.alu_src_i, bus.reg_write_i, bus.mem_read_i,
     bus.mem_write_i, bus.mem_to_reg_i, bus.branch_i} = p.ctrl;
    bus.pc_i         = p.pc;
    bus.rs1_data_i   = p.rs1_data;
    bus.rs2_data_i   = p.rs2_data;
    bus.imm_i        = p.imm;
    bus.rs1_addr_i   = p.rs1_addr;
    bus.rs2_addr_i   = p.rs2_addr;
    bus.rd_addr_i    = p.rd_addr;
    exp_q.push_back(exp);
    name_q.push_back(name);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    out_t act;
    out_t exp;
    string name;
    act.p.valid    = bus.valid_o;
    act.p.alu_op   = bus.alu_op_o;
    act.p.funct    = bus.funct_o;
    act.p.ctrl     = {bus.alu_src_o, bus.reg_write_o, bus.mem_read_o,
                      bus.mem_write_o, bus.mem_to_reg_o, bus.branch_o};
    act.p.pc       = bus.pc_o;
    act.p.rs1_data = bus.rs1_data_o;
    act.p.rs2_data = bus.rs2_data_o;
    act.p.imm      = bus.imm_o;
    act.p.rs1_addr = bus.rs1_addr_o;
    act.p.rs2_addr = bus.rs2_addr_o;
    act.p.rd_addr  = bus.rd_addr_o;
    act.cnt        = bus.bubble_cnt_o;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard: got output %h with no expected entry queued", act);
      return;
    end
    exp  = exp_q.pop_front();
    name = name_q.pop_front();
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input payload_t p,
                      input payload_t exp_p, input logic [3:0] cnt, input string name);
    out_t e;
    e.p = exp_p;
    e.cnt = cnt;
    applyStimulus(r, s, f, p, e, name);
    checkOutput();
  endtask

  initial begin
    payload_t spec_ld;
    payload_t beef;
    payload_t zero;
    payload_t v5;
    checks   = 0;
    failures = 0;
    zero     = '0;

    v5 = pl(1, 2'b10, 4'b0000, 6'b010000, 32'h114, 32'h5, 32'h6, 32'h0, 11, 12, 13);
    vecs[0]  = mkv(1, 0, 0, pl(1, 2'b10, 4'b1000, 6'b010000, 32'h100, 32'h10, 32'h3, 32'h4, 1, 2, 5),
                            pl(1, 2'b10, 4'b1000, 6'b010000, 32'h100, 32'h10, 32'h3, 32'h4, 1, 2, 5), 4'd0);
    vecs[1]  = mkv(1, 0, 0, pl(1, 2'b01, 4'b0000, 6'b000001, 32'h104, 32'h7, 32'h7, 32'hFFFF_FFF8, 3, 4, 0),
                            pl(1, 2'b01, 4'b0000, 6'b000001, 32'h104, 32'h7, 32'h7, 32'hFFFF_FFF8, 3, 4, 0), 4'd0);
    vecs[2]  = mkv(1, 0, 0, pl(0, 2'b10, 4'b0101, 6'b010100, 32'h108, 32'hAA, 32'hBB, 32'hCC, 6, 7, 8),
                            zero, 4'd1);
    vecs[3]  = mkv(1, 0, 0, pl(1, 2'b00, 4'b0010, 6'b111010, 32'h10C, 32'h2000, 32'h0, 32'h10, 9, 0, 10),
                            pl(1, 2'b00, 4'b0010, 6'b111010, 32'h10C, 32'h2000, 32'h0, 32'h10, 9, 0, 10), 4'd1);
    vecs[4]  = mkv(1, 1, 1, pl(1, 2'b10, 4'b0000, 6'b010100, 32'h110, 32'h1, 32'h2, 32'h3, 4, 5, 6),
                            zero, 4'd2);
    vecs[5]  = mkv(1, 0, 0, v5, v5, 4'd2);
    vecs[6]  = mkv(1, 1, 0, pl(1, 2'b01, 4'b1111, 6'b101011, 32'hDEAD_BEEF, 32'h9, 32'h9, 32'h9, 14, 15, 16),
                            v5, 4'd2);
    vecs[7]  = mkv(1, 1, 0, pl(0, 2'b11, 4'b0001, 6'b010100, 32'h200, 32'h1, 32'h1, 32'h1, 1, 1, 1),
                            v5, 4'd2);
    vecs[8]  = mkv(1, 0, 1, pl(1, 2'b10, 4'b0111, 6'b010000, 32'h118, 32'h4, 32'h4, 32'h4, 2, 2, 2),
                            zero, 4'd3);
    vecs[9]  = mkv(0, 0, 1, pl(1, 2'b10, 4'b0111, 6'b010000, 32'h11C, 32'h4, 32'h4, 32'h4, 2, 2, 2),
                            zero, 4'd0);
    vecs[10] = mkv(1, 0, 0, pl(1, 2'b11, 4'b1101, 6'b110000, 32'hFFFF_FFFC, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 31, 31, 31),
                            pl(1, 2'b11, 4'b1101, 6'b110000, 32'hFFFF_FFFC, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1, 31, 31, 31), 4'd0);

    // Reset held for two edges with random inputs.
    for (int i = 0; i < 2; i++) step(0, 1'($urandom), 1'($urandom), rand_payload(), zero, 4'd0, $sformatf("reset%0d", i));

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].stall, vecs[i].flush, vecs[i].in_p, vecs[i].exp, $sformatf("vec%0d", i));
      checkOutput();
    end

    // Three-cycle stall, then the new inputs appear one edge after release.
    spec_ld = pl(1, 2'b10, 4'b1000, 6'b010000, 32'h40, 32'h0000_0010, 32'h0000_0003, 32'h0, 1, 2, 5);
    beef    = pl(1, 2'b01, 4'b0111, 6'b010001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 7, 8, 9);
    step(1, 0, 0, spec_ld, spec_ld, 4'd0, "stall_load");
    for (int i = 0; i < 3; i++) step(1, 1, 0, beef, spec_ld, 4'd0, $sformatf("stall_hold%0d", i));
    step(1, 0, 0, beef, beef, 4'd0, "stall_release");

    // 17 flushes against a 4-bit counter: it must stop at 15.
    for (int i = 0; i < 17; i++)
      step(1, 0, 1, beef, zero, (i + 1 > 15) ? 4'd15 : 4'(i + 1), $sformatf("sat%0d", i));

    step(1, 0, 0, beef, beef, 4'd15, "sat_load");
    step(0, 1, 0, beef, zero, 4'd0, "reset_in_stall");
    step(1, 0, 0, spec_ld, spec_ld, 4'd0, "post_reset_load");
    step(1, 0, 0, pl(0, 2'b10, 4'b0000, 6'b010100, 32'h44, 32'h1, 32'h2, 32'h3, 1, 2, 3), zero, 4'd1, "invalid_load");

    if (exp_q.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, expected 0", exp_q.size());
    end
    checks++;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
